// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider on a shared accumulator.
// Define MDU_EARLY_OUT_EN to let divide-by-zero and signed-overflow operations skip the iteration phase.
module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] in_0,
    input  logic [XLEN-1:0] in_1,
    input  logic [2:0]      operation,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, b_q, b_d, a_q, a_d, out_q, out_d;
    logic [2:0]      op_q, op_d;
    logic            sign0_q, sign0_d, sign1_q, sign1_d;
    logic            divZero_q, divZero_d, ovf_q, ovf_d, done_q, done_d;

    logic            signed0, signed1, neg0, neg1, inDivZero, inOvf;
    logic [XLEN-1:0] mag0, mag1;

    always_comb begin
        signed0   = (operation == OP_MULH) || (operation == OP_MULHSU) ||
                    (operation == OP_DIV)  || (operation == OP_REM);
        signed1   = (operation == OP_MULH) || (operation == OP_DIV) || (operation == OP_REM);
        neg0      = signed0 && in_0[XLEN-1];
        neg1      = signed1 && in_1[XLEN-1];
        mag0      = neg0 ? -in_0 : in_0;
        mag1      = neg1 ? -in_1 : in_1;
        inDivZero = operation[2] && (in_1 == '0);
        inOvf     = ((operation == OP_DIV) || (operation == OP_REM)) &&
                    (in_0 == MIN_NEG) && (in_1 == '1);
    end

    // lo_q holds the multiplier (shifted out LSB first) or the dividend/quotient (shifted left).
    logic [XLEN:0]   addSum, trial, diff;
    logic [XLEN-1:0] iterAcc, iterLo;

    always_comb begin
        addSum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        trial  = {acc_q, lo_q[XLEN-1]};
        diff   = trial - {1'b0, b_q};
        if (op_q[2]) begin
            if (diff[XLEN]) begin
                iterAcc = trial[XLEN-1:0];
                iterLo  = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                iterAcc = diff[XLEN-1:0];
                iterLo  = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            iterAcc = addSum[XLEN:1];
            iterLo  = {addSum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] product, prodSigned;
    logic [XLEN-1:0]   quotSigned, remSigned, result;

    always_comb begin
        product    = {acc_q, lo_q};
        prodSigned = (sign0_q ^ sign1_q) ? -product : product;
        quotSigned = (sign0_q ^ sign1_q) ? -lo_q : lo_q;
        remSigned  = sign0_q ? -acc_q : acc_q;
        result     = '0;
        case (op_q)
            OP_MUL:                        result = prodSigned[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prodSigned[2*XLEN-1:XLEN];
            OP_DIV:  result = divZero_q ? '1 : (ovf_q ? a_q : quotSigned);
            OP_DIVU: result = divZero_q ? '1 : lo_q;
            OP_REM:  result = divZero_q ? a_q : (ovf_q ? '0 : remSigned);
            default: result = divZero_q ? a_q : acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        b_d       = b_q;
        a_d       = a_q;
        op_d      = op_q;
        sign0_d   = sign0_q;
        sign1_d   = sign1_q;
        divZero_d = divZero_q;
        ovf_d     = ovf_q;
        out_d     = out_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = in_0;
                    lo_d      = mag0;
                    b_d       = mag1;
                    acc_d     = '0;
                    op_d      = operation;
                    sign0_d   = neg0;
                    sign1_d   = neg1;
                    divZero_d = inDivZero;
                    ovf_d     = inOvf;
                    cnt_d     = CW'(XLEN);
`ifdef MDU_EARLY_OUT_EN
                    state_d   = (inDivZero || inOvf) ? FINISH : CALC;
`else
                    state_d   = CALC;
`endif
                end
            end
            CALC: begin
                acc_d = iterAcc;
                lo_d  = iterLo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                out_d   = result;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            a_q       <= '0;
            op_q      <= '0;
            sign0_q   <= 1'b0;
            sign1_q   <= 1'b0;
            divZero_q <= 1'b0;
            ovf_q     <= 1'b0;
            out_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            a_q       <= a_d;
            op_q      <= op_d;
            sign0_q   <= sign0_d;
            sign1_q   <= sign1_d;
            divZero_q <= divZero_d;
            ovf_q     <= ovf_d;
            out_q     <= out_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu (XLEN=32): directed vector table, handshake/reset sequences
// and randomized operations against an arithmetic reference model.
module tb_mdu;

    localparam int XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk;
    logic        reset;
    logic [31:0] in0, in1;
    logic [2:0]  operation;
    logic        start;
    logic        busy, done;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_0(in0), .in_1(in1), .operation(operation),
        .start(start), .busy(busy), .done(done), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs[13];

    // Reference results straight from the RV32M definitions using 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic        overflow;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        overflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p = '0;
        case (op)
            MUL:    begin p = ua * ub; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV:    return (b == 0) ? 32'hFFFF_FFFF : (overflow ? a : 32'(sa / sb));
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    return (b == 0) ? a : (overflow ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = op[2] && ((b == 0) ||
                  (((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        return (EARLY && special) ? 1 : XLEN + 1;
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one operation, scramble the inputs after acceptance, and measure accept-to-done latency.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat);
        @(negedge clk);
        operation = op;
        in0       = a;
        in1       = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        operation = 3'($urandom);
        in0       = $urandom;
        in1       = $urandom;
        checkOutput("busyAfterAccept", 32'(busy), 32'd1);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        res = out;
        if (done) begin
            checkOutput("busyAtDone", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            checkOutput("donePulseWidth", 32'(done), 32'd0);
            checkOutput("outHolds", out, res);
        end
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected);
        logic [31:0] res;
        int          lat;
        applyStimulus(op, a, b, res, lat);
        checkOutput(name, res, expected);
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLatency(op, a, b)));
    endtask

    initial begin
        int          nDone, firstEdge, secondEdge, lat;
        bit          found;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset     = 1'b1;
        start     = 1'b0;
        operation = MUL;
        in0       = '0;
        in1       = '0;
        #1;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetOut", out, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        vecs[0]  = '{MUL,    32'd3,          32'd5,          32'd15};
        vecs[1]  = '{MUL,    32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE};
        vecs[2]  = '{MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
        vecs[3]  = '{MULHU,  32'hFFFF_FFFF,  32'd2,          32'h0000_0001};
        vecs[4]  = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[5]  = '{DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[6]  = '{REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[7]  = '{DIVU,   32'd7,          32'd2,          32'd3};
        vecs[8]  = '{REMU,   32'd7,          32'd2,          32'd1};
        vecs[9]  = '{DIV,    32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[10] = '{REM,    32'd5,          32'd0,          32'd5};
        vecs[11] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[12] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0};

        for (int i = 0; i < 13; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expected);
        end

        // Reset in the middle of an iteration discards the operation.
        runOp("mul7x9", MUL, 32'd7, 32'd9, 32'd63);
        @(negedge clk);
        operation = MUL;
        in0       = 32'd11;
        in1       = 32'd13;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        checkOutput("midResetDone", 32'(done), 32'd0);
        checkOutput("midResetOut", out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) nDone++;
        end
        checkOutput("noDoneAfterReset", 32'(nDone), 32'd0);
        runOp("mulAfterReset", MUL, 32'd3, 32'd5, 32'd15);

        // start held high: one accept per XLEN+2 cycles.
        @(negedge clk);
        operation  = MUL;
        in0        = 32'd6;
        in1        = 32'd7;
        start      = 1'b1;
        nDone      = 0;
        firstEdge  = -1;
        secondEdge = -1;
        for (int e = 0; e < 70; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nDone++;
                if (firstEdge < 0) firstEdge = e;
                else if (secondEdge < 0) secondEdge = e;
                checkOutput("heldResult", out, 32'd42);
            end
        end
        start = 1'b0;
        checkOutput("heldDoneCount", 32'(nDone), 32'd2);
        checkOutput("heldFirstDone", 32'(firstEdge), 32'(XLEN + 1));
        checkOutput("heldGap", 32'(secondEdge - firstEdge), 32'(XLEN + 2));
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("heldDrain", 32'(found), 32'd1);
        checkOutput("heldDrainResult", out, 32'd42);

        // A start pulse while busy is ignored; operand changes during CALC have no effect.
        @(negedge clk);
        operation = DIVU;
        in0       = 32'd100;
        in1       = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 6) begin
                start     = 1'b1;
                operation = MUL;
                in0       = 32'd2;
                in1       = 32'd2;
            end
            if (k == 7) start = 1'b0;
            if (k == 12) in0 = 32'h1234_5678;
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        checkOutput("ignoreStartLatency", 32'(lat), 32'(XLEN + 1));
        checkOutput("ignoreStartResult", out, 32'd14);
        nDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) nDone++;
        end
        checkOutput("ignoreStartNoExtraDone", 32'(nDone), 32'd0);
        checkOutput("ignoreStartIdle", 32'(busy), 32'd0);

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = randOperand();
            rb  = randOperand();
            runOp($sformatf("rand%0d_op%0d_%08h_%08h", i, rop, ra, rb), rop, ra, rb, refModel(rop, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
